iobus_master: RTL and testbench
===============================

IOBUS_MASTER -- requirements
Module: iobus_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles to wait for IO_Ready after a strobe.
REQ-002 Parameter: ADDR_STEP, default 4, byte address increment between burst words.
REQ-003 Clk  input  1  sole clock, all logic rising-edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high when the block can accept a command (IDLE).
REQ-007 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  32  start byte address.
REQ-009 cmd_len  input  8  burst length minus one (0 = 1 word, 255 = 256 words).
REQ-010 cmd_be  input  4  byte enables, applied to every write word.
REQ-011 cmd_wdata  input  32  write data for the current word, sampled at each write strobe.
REQ-012 wdata_req  output  1  one-cycle pulse: cmd_wdata consumed, present the next word.
REQ-013 rsp_valid  output  1  one-cycle pulse per completed word (no backpressure).
REQ-014 rsp_rdata  output  32  read data, valid with rsp_valid on reads, 0 on writes.
REQ-015 rsp_last  output  1  with rsp_valid: final word of the burst, or aborted burst.
REQ-016 rsp_error  output  1  with rsp_valid: word timed out.
REQ-017 IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe  output  1 each  bus strobes.
REQ-018 IO_Address  output  32; IO_Byte_Enable  output  4; IO_Write_Data  output  32.
REQ-019 IO_Read_Data  input  32; IO_Ready  input  1  slave completion.

Function
REQ-020 States: IDLE, STROBE, WAIT, RESP; the FSM SHALL use no other states.
REQ-021 IDLE: cmd_ready=1; cmd_valid=1 latches addr, len, be, write, clears word count, goes to STROBE.
REQ-022 STROBE, one cycle: IO_Addr_Strobe=1 plus exactly one of IO_Read_Strobe/IO_Write_Strobe; IO_Address = current address; on writes IO_Byte_Enable=be and IO_Write_Data=cmd_wdata; wdata_req=1 on writes; then WAIT.
REQ-023 Outside STROBE, all strobes SHALL be 0 and IO_Byte_Enable SHALL be 0.
REQ-024 IO_Ready SHALL be ignored during STROBE (a stale high from the slave SHALL NOT complete the word).
REQ-025 WAIT: IO_Ready=1 captures IO_Read_Data (reads) and goes to RESP; minimum strobe-to-response latency is 2 cycles.
REQ-026 RESP, one cycle: rsp_valid=1; rsp_last=1 when word count == len; then IDLE if last, else address += ADDR_STEP, count++, STROBE.
REQ-027 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-028 cmd_valid outside IDLE SHALL be ignored; no command queuing.
REQ-029 The word counter is 8 bits; len=255 yields exactly 256 responses.

Reset
REQ-030 Reset SHALL force IDLE, cmd_ready=1, and all other outputs, address, counter and timeout counter to 0.
REQ-031 Reset asserted mid-burst SHALL abort immediately with no rsp_valid pulse; deassertion returns to IDLE.

Configuration
REQ-032 With IOBUS_MASTER_TIMEOUT_EN defined: a counter is cleared in STROBE and increments in WAIT.
REQ-033 With IOBUS_MASTER_TIMEOUT_EN defined: reaching TIMEOUT_CYCLES without IO_Ready SHALL go to RESP with rsp_error=1, rsp_last=1, rsp_rdata=0, and the rest of the burst SHALL be dropped.
REQ-034 Without IOBUS_MASTER_TIMEOUT_EN: WAIT persists until IO_Ready, rsp_error is tied 0, and no counter logic is instantiated.

Structure
REQ-035 Shared include iobus_defs.vh SHALL hold the FSM state encodings, the IO bus address/data/byte-enable widths and the default TIMEOUT_CYCLES.
REQ-036 Timeout counter SHALL be sub-module iobus_timeout_cnt (clear, enable, expired), instantiated only under IOBUS_MASTER_TIMEOUT_EN.

Verification
REQ-037 Single read: addr=0xC0001000, len=0, slave IO_Ready 1 cycle after strobe with data 0xDEADBEEF -> one rsp_valid, rsp_rdata=0xDEADBEEF, rsp_last=1, 3 cycles after command accept.
REQ-038 Write burst: addr=0xC0001000, len=3, be=0xF, data 1..4 -> strobes at addresses 0x...1000/1004/1008/100C with data 1..4, 4 wdata_req pulses, rsp_last only on the 4th.
REQ-039 Wrap: read addr=0xFFFFFFF8, len=2 -> IO_Address sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-040 Stale ready: IO_Ready held 1 through STROBE, then low 3 cycles, then high -> word completes only after that final high.
REQ-041 Timeout (macro on, TIMEOUT_CYCLES=8): IO_Ready never asserts on word 1 of len=3 -> rsp_error=1, rsp_last=1 after 8 WAIT cycles, no further strobes; macro off -> stays in WAIT.
REQ-042 Reset asserted during WAIT of word 2 -> all strobes 0, cmd_ready=1 next cycle, no rsp_valid.

Source files
------------

// File: rtl/iobus_master_pkg.sv
// IO bus master package: widths, state constants and the address-step helper.
package iobus_master_pkg;
`include "iobus_defs.vh"

    localparam int AW              = `IOBUS_AW;
    localparam int DW              = `IOBUS_DW;
    localparam int BEW             = `IOBUS_BEW;
    localparam int LENW            = 8;
    localparam int TIMEOUT_DEFAULT = `IOBUS_TIMEOUT_DEFAULT;

    localparam logic [1:0] ST_IDLE   = `IOBUS_ST_IDLE;
    localparam logic [1:0] ST_STROBE = `IOBUS_ST_STROBE;
    localparam logic [1:0] ST_WAIT   = `IOBUS_ST_WAIT;
    localparam logic [1:0] ST_RESP   = `IOBUS_ST_RESP;

    // Plain unsigned add so the burst address wraps modulo 2^AW.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input int step);
        return a + AW'(step);
    endfunction
endpackage

// File: rtl/iobus_master_if.sv
// Command/response and IO bus signals of the burst master, with master/slave views.
interface iobus_master_if;
    import iobus_master_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic [BEW-1:0]  cmd_be;
    logic [DW-1:0]   cmd_wdata;
    logic            wdata_req;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_last;
    logic            rsp_error;
    logic            IO_Addr_Strobe;
    logic            IO_Read_Strobe;
    logic            IO_Write_Strobe;
    logic [AW-1:0]   IO_Address;
    logic [BEW-1:0]  IO_Byte_Enable;
    logic [DW-1:0]   IO_Write_Data;
    logic [DW-1:0]   IO_Read_Data;
    logic            IO_Ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, cmd_wdata,
               IO_Read_Data, IO_Ready,
        output cmd_ready, wdata_req, rsp_valid, rsp_rdata, rsp_last, rsp_error,
               IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
               IO_Address, IO_Byte_Enable, IO_Write_Data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, cmd_wdata,
               IO_Read_Data, IO_Ready,
        input  cmd_ready, wdata_req, rsp_valid, rsp_rdata, rsp_last, rsp_error,
               IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
               IO_Address, IO_Byte_Enable, IO_Write_Data
    );
endinterface

// File: rtl/iobus_defs.vh
// Shared IO bus constants: FSM state encodings, bus widths and default timeout.
`ifndef IOBUS_DEFS_VH
`define IOBUS_DEFS_VH

`define IOBUS_ST_IDLE          2'd0
`define IOBUS_ST_STROBE        2'd1
`define IOBUS_ST_WAIT          2'd2
`define IOBUS_ST_RESP          2'd3

`define IOBUS_AW               32
`define IOBUS_DW               32
`define IOBUS_BEW              4

`define IOBUS_TIMEOUT_DEFAULT  255

`endif

// File: rtl/iobus_timeout_cnt.sv
// Wait-cycle counter; expired is high in the TIMEOUT_CYCLES-th enabled cycle.
module iobus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    // Compare against N-1 so the FSM leaves WAIT after exactly N idle cycles.
    assign expired = enable && (cnt == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/iobus_master.sv
// Burst IO bus master: one strobe per word, waits for IO_Ready, one response pulse per word.
// Optional per-word timeout enabled by defining IOBUS_MASTER_TIMEOUT_EN.
module iobus_master
    import iobus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int ADDR_STEP      = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    iobus_master_if.master bus
);
    logic [1:0]      state;
    logic [AW-1:0]   addr_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt_q;
    logic [BEW-1:0]  be_q;
    logic            wr_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            to_expired;
    logic            st_strobe;
    logic            st_resp;
    logic            last_word;

    assign st_strobe = (state == ST_STROBE);
    assign st_resp   = (state == ST_RESP);
    // A timed-out word also ends the burst; the remaining words are dropped.
    assign last_word = (cnt_q == len_q) || err_q;

`ifdef IOBUS_MASTER_TIMEOUT_EN
    iobus_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (st_strobe),
        .enable  (state == ST_WAIT),
        .expired (to_expired)
    );
`else
    logic unused_timeout;
    assign to_expired     = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q <= bus.cmd_addr;
                        len_q  <= bus.cmd_len;
                        be_q   <= bus.cmd_be;
                        wr_q   <= bus.cmd_write;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                        state  <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // IO_Ready is deliberately not looked at here: a stale high must not finish the word.
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.IO_Ready) begin
                        if (!wr_q)
                            rdata_q <= bus.IO_Read_Data;
                        state <= ST_RESP;
                    end else if (to_expired) begin
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (last_word) begin
                        state <= ST_IDLE;
                    end else begin
                        addr_q <= next_addr(addr_q, ADDR_STEP);
                        cnt_q  <= cnt_q + 1'b1;
                        state  <= ST_STROBE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode from state so an asynchronous reset clears them at once.
    assign bus.cmd_ready       = (state == ST_IDLE);
    assign bus.IO_Addr_Strobe  = st_strobe;
    assign bus.IO_Read_Strobe  = st_strobe && !wr_q;
    assign bus.IO_Write_Strobe = st_strobe && wr_q;
    assign bus.IO_Address      = addr_q;
    assign bus.IO_Byte_Enable  = (st_strobe && wr_q) ? be_q : '0;
    assign bus.IO_Write_Data   = (st_strobe && wr_q) ? bus.cmd_wdata : '0;
    assign bus.wdata_req       = st_strobe && wr_q;

    assign bus.rsp_valid = st_resp;
    assign bus.rsp_last  = st_resp && last_word;
    assign bus.rsp_error = st_resp && err_q;
    assign bus.rsp_rdata = (st_resp && !wr_q) ? rdata_q : '0;
endmodule

// File: tb/tb_iobus_master.sv
// Directed bench for iobus_master: reset, single read, write burst, wrap, stale ready, timeout, mid-burst reset.
module tb_iobus_master;
    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    iobus_master_if bus();

    iobus_master #(.TIMEOUT_CYCLES(8), .ADDR_STEP(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_len      = '0;
        bus.cmd_be       = '0;
        bus.cmd_wdata    = '0;
        bus.IO_Read_Data = '0;
        bus.IO_Ready     = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        Reset = 1'b1;
        tick(); tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
        total++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b exp=000", {bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}); end
        total++; if ({bus.rsp_valid, bus.rsp_last, bus.rsp_error, bus.wdata_req} !== 4'b0000) begin bad++; $display("FAIL rst_rsp got=%b exp=0000", {bus.rsp_valid, bus.rsp_last, bus.rsp_error, bus.wdata_req}); end
        total++; if (bus.IO_Address !== 32'h0 || bus.IO_Byte_Enable !== 4'h0) begin bad++; $display("FAIL rst_addr_be got=%h/%h exp=0/0", bus.IO_Address, bus.IO_Byte_Enable); end
        Reset = 1'b0;
        tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_single_read;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'hC000_1000; bus.cmd_len = 8'd0; bus.cmd_be = 4'hF;
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_accept got=%b exp=1", bus.cmd_ready); end
        tick(); // strobe
        bus.cmd_valid = 1'b0;
        total++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe} !== 3'b110) begin bad++; $display("FAIL rd_strobe got=%b exp=110", {bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}); end
        total++; if (bus.IO_Address !== 32'hC000_1000) begin bad++; $display("FAIL rd_addr got=%h exp=c0001000", bus.IO_Address); end
        tick(); // wait
        total++; if (bus.rsp_valid !== 1'b0 || bus.IO_Addr_Strobe !== 1'b0) begin bad++; $display("FAIL rd_wait got=%b%b exp=00", bus.rsp_valid, bus.IO_Addr_Strobe); end
        bus.IO_Ready = 1'b1; bus.IO_Read_Data = 32'hDEAD_BEEF;
        tick(); // response, third cycle after accept
        bus.IO_Ready = 1'b0; bus.IO_Read_Data = '0;
        total++; if ({bus.rsp_valid, bus.rsp_last, bus.rsp_error} !== 3'b110) begin bad++; $display("FAIL rd_rsp got=%b exp=110", {bus.rsp_valid, bus.rsp_last, bus.rsp_error}); end
        total++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", bus.rsp_rdata); end
        tick();
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_done got=%b%b exp=01", bus.rsp_valid, bus.cmd_ready); end
    endtask

    task automatic test_write_burst;
        int wreq = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'hC000_1000; bus.cmd_len = 8'd3; bus.cmd_be = 4'hF;
        tick();
        // A different command held valid mid-burst must be ignored.
        bus.cmd_addr = 32'h5555_0000; bus.cmd_write = 1'b0; bus.cmd_len = 8'd0;
        for (int w = 0; w < 4; w++) begin
            bus.cmd_wdata = 32'(w + 1);
            #1;
            total++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe} !== 3'b101) begin bad++; $display("FAIL wr_strobe%0d got=%b exp=101", w, {bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}); end
            total++; if (bus.IO_Address !== 32'hC000_1000 + 32'(4 * w)) begin bad++; $display("FAIL wr_addr%0d got=%h exp=%h", w, bus.IO_Address, 32'hC000_1000 + 32'(4 * w)); end
            total++; if (bus.IO_Write_Data !== 32'(w + 1) || bus.IO_Byte_Enable !== 4'hF) begin bad++; $display("FAIL wr_data%0d got=%h/%h exp=%h/f", w, bus.IO_Write_Data, bus.IO_Byte_Enable, w + 1); end
            wreq += int'(bus.wdata_req);
            tick(); // wait
            total++; if (bus.IO_Byte_Enable !== 4'h0 || bus.IO_Write_Strobe !== 1'b0) begin bad++; $display("FAIL wr_wait_be%0d got=%h/%b exp=0/0", w, bus.IO_Byte_Enable, bus.IO_Write_Strobe); end
            wreq += int'(bus.wdata_req);
            bus.IO_Ready = 1'b1;
            tick(); // response
            bus.IO_Ready = 1'b0;
            if (w == 3) bus.cmd_valid = 1'b0;
            wreq += int'(bus.wdata_req);
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== (w == 3) || bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp%0d got=%b%b/%h exp=1%b/0", w, bus.rsp_valid, bus.rsp_last, bus.rsp_rdata, w == 3); end
            tick();
        end
        total++; if (bus.cmd_ready !== 1'b1 || bus.IO_Addr_Strobe !== 1'b0) begin bad++; $display("FAIL wr_done got=%b%b exp=10", bus.cmd_ready, bus.IO_Addr_Strobe); end
        total++; if (wreq !== 4) begin bad++; $display("FAIL wr_wdata_req_count got=%0d exp=4", wreq); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'hFFFF_FFF8; bus.cmd_len = 8'd2;
        tick();
        bus.cmd_valid = 1'b0;
        for (int w = 0; w < 3; w++) begin
            total++; if (bus.IO_Read_Strobe !== 1'b1 || bus.IO_Address !== exp_addr[w]) begin bad++; $display("FAIL wrap_addr%0d got=%b/%h exp=1/%h", w, bus.IO_Read_Strobe, bus.IO_Address, exp_addr[w]); end
            tick();
            bus.IO_Ready = 1'b1; bus.IO_Read_Data = 32'hA0 + 32'(w);
            tick();
            bus.IO_Ready = 1'b0;
            total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== (w == 2) || bus.rsp_rdata !== 32'hA0 + 32'(w)) begin bad++; $display("FAIL wrap_rsp%0d got=%b%b/%h exp=1%b/%h", w, bus.rsp_valid, bus.rsp_last, bus.rsp_rdata, w == 2, 32'hA0 + 32'(w)); end
            tick();
        end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_stale_ready;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40; bus.cmd_len = 8'd0;
        bus.IO_Ready = 1'b1; bus.IO_Read_Data = 32'hBAD0_BAD0;
        tick(); // strobe with ready already high
        bus.cmd_valid = 1'b0;
        total++; if (bus.IO_Read_Strobe !== 1'b1) begin bad++; $display("FAIL stale_strobe got=%b exp=1", bus.IO_Read_Strobe); end
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.IO_Ready = 1'b0;
            total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stale_wait%0d rsp_valid got=%b exp=0", i, bus.rsp_valid); end
            tick();
        end
        bus.IO_Ready = 1'b1; bus.IO_Read_Data = 32'h1234_5678;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stale_wait3 rsp_valid got=%b exp=0", bus.rsp_valid); end
        tick();
        bus.IO_Ready = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL stale_rsp got=%b/%h exp=1/12345678", bus.rsp_valid, bus.rsp_rdata); end
        tick();
    endtask

    task automatic test_timeout;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h100; bus.cmd_len = 8'd3;
        tick();
        bus.cmd_valid = 1'b0;
        total++; if (bus.IO_Read_Strobe !== 1'b1) begin bad++; $display("FAIL to_strobe got=%b exp=1", bus.IO_Read_Strobe); end
        tick();
`ifdef IOBUS_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.rsp_valid !== 1'b0 || bus.IO_Addr_Strobe !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b%b exp=00", i, bus.rsp_valid, bus.IO_Addr_Strobe); end
            tick();
        end
        total++; if ({bus.rsp_valid, bus.rsp_last, bus.rsp_error} !== 3'b111 || bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got=%b/%h exp=111/0", {bus.rsp_valid, bus.rsp_last, bus.rsp_error}, bus.rsp_rdata); end
        tick();
        total++; if (bus.cmd_ready !== 1'b1 || bus.IO_Addr_Strobe !== 1'b0) begin bad++; $display("FAIL to_idle got=%b%b exp=10", bus.cmd_ready, bus.IO_Addr_Strobe); end
        tick();
        total++; if (bus.IO_Addr_Strobe !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL to_dropped got=%b%b exp=00", bus.IO_Addr_Strobe, bus.rsp_valid); end
`else
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL to_stuck%0d got=%b%b exp=00", i, bus.rsp_valid, bus.cmd_ready); end
            tick();
        end
        Reset = 1'b1; tick();
        Reset = 1'b0; tick();
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL to_recover got=%b exp=1", bus.cmd_ready); end
`endif
    endtask

    task automatic test_reset_mid_burst;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h200; bus.cmd_len = 8'd3;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.IO_Ready = 1'b1; bus.IO_Read_Data = 32'h1;
        tick();
        bus.IO_Ready = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_last !== 1'b0) begin bad++; $display("FAIL mid_rsp0 got=%b%b exp=10", bus.rsp_valid, bus.rsp_last); end
        tick();
        total++; if (bus.IO_Address !== 32'h204) begin bad++; $display("FAIL mid_addr1 got=%h exp=204", bus.IO_Address); end
        tick(); // wait of word 2
        Reset = 1'b1; bus.IO_Ready = 1'b1;
        tick();
        total++; if ({bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe} !== 3'b000 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got=%b/%b exp=000/1", {bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, bus.cmd_ready); end
        total++; if (bus.rsp_valid !== 1'b0 || bus.IO_Address !== 32'h0) begin bad++; $display("FAIL mid_reset_rsp got=%b/%h exp=0/0", bus.rsp_valid, bus.IO_Address); end
        Reset = 1'b0; bus.IO_Ready = 1'b0;
        tick();
        total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%b%b exp=01", bus.rsp_valid, bus.cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_wrap();
        test_stale_ready();
        test_timeout();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
